intr_req_ctrl: RTL and testbench

Interrupt request controller that sits between device interrupt lines and the coprocessor-0 block of the pipeline CPU. It synchronises eight IRQ lines and a built-in interval timer, then holds per-line pending state. It drives the 8-bit pending vector that CP0 samples into its cause IP field (bits 15:8), and runs a request/acknowledge/return handshake with CP0 and the control unit so that exactly one interrupt is in service at a time.

---
 rtl/intr_req_ctrl.sv | 168 ++++++++++++++++
 tb/tb_intr_req_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/intr_req_ctrl.sv
// Interrupt request controller: synchronises eight device IRQ lines plus an interval
// timer, tracks per-line pending state and runs the req/ack/eret handshake with CP0.

module intr_line (
  input  logic Clk,
  input  logic Rst,
  input  logic irq,
  input  logic edge_mode,
  input  logic clr,
  input  logic tmr_fire,
  output logic pending
);
  logic sync1, sync2, sync3, tmr_hold;
  logic rise, tmr_keep;

  assign rise = sync2 & ~sync3;
  // A timer event latches even in level mode; only a clear releases it.
  assign tmr_keep = tmr_fire | (tmr_hold & ~clr);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      tmr_hold <= 1'b0;
      pending  <= 1'b0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      sync3 <= sync2;
      if (edge_mode) begin
        tmr_hold <= 1'b0;
        if (rise | tmr_fire) pending <= 1'b1;
        else if (clr)        pending <= 1'b0;
      end else begin
        tmr_hold <= tmr_keep;
        pending  <= sync2 | tmr_keep;
      end
    end
  end
endmodule

module intr_req_ctrl #(
  parameter int TIMER_WIDTH = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  Dev_irq,
  input  logic        Cfg_w_en,
  input  logic [1:0]  Cfg_addr,
  input  logic [31:0] Cfg_data,
  output logic [31:0] Cfg_rd_data,
  input  logic        Cp0_intr,
  input  logic        Eret,
  output logic [7:0]  Intr_pending,
  output logic        Intr_req,
  output logic [2:0]  Intr_id,
  output logic        In_service
);
  localparam int NUM_LINES = 8;
  localparam logic [TIMER_WIDTH-1:0] TMR_ONE = 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  typedef struct packed {
    logic edge_mask;
    logic enable;
    logic compare;
    logic w1c;
  } cfg_sel_t;

  state_t                 state, state_nxt;
  cfg_sel_t               wr;
  logic [NUM_LINES-1:0]   edge_mask, enable, pending, active, clr, tmr_vec;
  logic [TIMER_WIDTH-1:0] compare, counter;
  logic                   tmr_fire, ack;

  always_comb begin
    wr           = '0;
    wr.edge_mask = Cfg_w_en && (Cfg_addr == 2'd0);
    wr.enable    = Cfg_w_en && (Cfg_addr == 2'd1);
    wr.compare   = Cfg_w_en && (Cfg_addr == 2'd2);
    wr.w1c       = Cfg_w_en && (Cfg_addr == 2'd3);
  end

  // Counter walks 0..compare-1; the wrap cycle is the timer event.
  assign tmr_fire = (compare != '0) && (counter == compare - TMR_ONE);
  assign tmr_vec  = {tmr_fire, {(NUM_LINES-1){1'b0}}};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      edge_mask <= '0;
      enable    <= '0;
      compare   <= '0;
      counter   <= '0;
    end else begin
      if (wr.edge_mask) edge_mask <= Cfg_data[7:0];
      if (wr.enable)    enable    <= Cfg_data[7:0];
      if (wr.compare) begin
        compare <= Cfg_data[TIMER_WIDTH-1:0];
        counter <= '0;
      end else if (compare != '0) begin
        counter <= tmr_fire ? '0 : counter + TMR_ONE;
      end
    end
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    assign clr[i] = (wr.w1c & Cfg_data[i]) | (ack & (Intr_id == 3'(i)));
    intr_line u_line (
      .Clk       (Clk),
      .Rst       (Rst),
      .irq       (Dev_irq[i]),
      .edge_mode (edge_mask[i]),
      .clr       (clr[i]),
      .tmr_fire  (tmr_vec[i]),
      .pending   (pending[i])
    );
  end

  assign active       = pending & enable;
  assign Intr_pending = active;

  always_comb begin
    Intr_id = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (active[i]) Intr_id = 3'(i);
  end

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    case (state)
      IDLE:    if (|active) state_nxt = REQ;
      REQ: begin
        if (Cp0_intr) begin
          state_nxt = SERVICE;
          ack       = 1'b1;
        end else if (!(|active)) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: if (Eret) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      Intr_req   <= 1'b0;
      In_service <= 1'b0;
    end else begin
      state      <= state_nxt;
      Intr_req   <= (state_nxt == REQ);
      In_service <= (state_nxt == SERVICE);
    end
  end

  always_comb begin
    Cfg_rd_data = '0;
    case (Cfg_addr)
      2'd0:    Cfg_rd_data[7:0] = edge_mask;
      2'd1:    Cfg_rd_data[7:0] = enable;
      2'd2:    Cfg_rd_data[TIMER_WIDTH-1:0] = compare;
      default: Cfg_rd_data[7:0] = pending;
    endcase
  end
endmodule

// File: tb/tb_intr_req_ctrl.sv
// Directed bench for intr_req_ctrl: cycle vector table plus timer and reset sequences.

module tb_intr_req_ctrl;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  Dev_irq;
  logic        Cfg_w_en;
  logic [1:0]  Cfg_addr;
  logic [31:0] Cfg_data;
  logic [31:0] Cfg_rd_data;
  logic        Cp0_intr;
  logic        Eret;
  logic [7:0]  Intr_pending;
  logic        Intr_req;
  logic [2:0]  Intr_id;
  logic        In_service;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  intr_req_ctrl #(.TIMER_WIDTH(32)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Dev_irq      (Dev_irq),
    .Cfg_w_en     (Cfg_w_en),
    .Cfg_addr     (Cfg_addr),
    .Cfg_data     (Cfg_data),
    .Cfg_rd_data  (Cfg_rd_data),
    .Cp0_intr     (Cp0_intr),
    .Eret         (Eret),
    .Intr_pending (Intr_pending),
    .Intr_req     (Intr_req),
    .Intr_id      (Intr_id),
    .In_service   (In_service)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [7:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        ack;
    logic        eret;
    logic        req;
    logic        svc;
    logic [2:0]  id;
    logic [7:0]  pend;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic rst, logic [7:0] irq, logic we, logic [1:0] a,
                              logic [31:0] d, logic ack, logic eret, logic req, logic svc,
                              logic [2:0] id, logic [7:0] pend, logic chk_rd = 1'b0,
                              logic [31:0] rd = 32'h0);
    vec_t v;
    v.name = n; v.rst = rst; v.irq = irq; v.we = we; v.addr = a; v.data = d;
    v.ack = ack; v.eret = eret; v.req = req; v.svc = svc; v.id = id; v.pend = pend;
    v.chk_rd = chk_rd; v.rd = rd;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, then sample 1ns after the rising edge.
  task automatic drive(input logic rst, input logic [7:0] irq, input logic we,
                       input logic [1:0] a, input logic [31:0] d, input logic ack,
                       input logic eret);
    Rst = rst; Dev_irq = irq; Cfg_w_en = we; Cfg_addr = a; Cfg_data = d;
    Cp0_intr = ack; Eret = eret;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_out(input string n, input logic req, input logic svc,
                           input logic [2:0] id, input logic [7:0] pend);
    tests++;
    if ({Intr_req, In_service, Intr_id, Intr_pending} !== {req, svc, id, pend}) begin
      fails++;
      $display("FAIL %s: req/svc/id/pend got %b/%b/%0d/%h want %b/%b/%0d/%h", n,
               Intr_req, In_service, Intr_id, Intr_pending, req, svc, id, pend);
    end
  endtask

  task automatic check_val(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, got, exp);
    end
  endtask

  initial begin
    //   name        rst irq   we a  data   ack er  req svc id pend  chk rd
    add("reset",     1, 8'h00, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00, 1, 32'h0);
    add("wr_en01",   0, 8'h00, 1, 1, 32'h01, 0, 0,  0, 0, 0, 8'h00, 1, 32'h01);
    add("wr_edge01", 0, 8'h00, 1, 0, 32'h01, 0, 0,  0, 0, 0, 8'h00, 1, 32'h01);
    add("e0_sync1",  0, 8'h01, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);
    add("e0_sync2",  0, 8'h00, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);
    add("e0_pend",   0, 8'h00, 0, 3, 32'h0,  0, 0,  0, 0, 0, 8'h01, 1, 32'h01);
    add("e0_req",    0, 8'h00, 0, 0, 32'h0,  0, 0,  1, 0, 0, 8'h01);
    add("e0_ack",    0, 8'h00, 0, 3, 32'h0,  1, 0,  0, 1, 0, 8'h00, 1, 32'h00);
    add("e0_svc",    0, 8'h00, 0, 0, 32'h0,  0, 0,  0, 1, 0, 8'h00);
    add("e0_eret",   0, 8'h00, 0, 0, 32'h0,  0, 1,  0, 0, 0, 8'h00);
    add("e0_idle",   0, 8'h00, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);
    add("wr_en08",   0, 8'h00, 1, 1, 32'h08, 0, 0,  0, 0, 0, 8'h00);
    add("l3_sync1",  0, 8'h08, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);
    add("l3_sync2",  0, 8'h08, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);
    add("l3_pend",   0, 8'h08, 0, 0, 32'h0,  0, 0,  0, 0, 3, 8'h08);
    add("l3_req",    0, 8'h08, 0, 0, 32'h0,  0, 0,  1, 0, 3, 8'h08);
    add("l3_ack",    0, 8'h08, 0, 0, 32'h0,  1, 0,  0, 1, 3, 8'h08);
    add("l3_eret",   0, 8'h08, 0, 0, 32'h0,  0, 1,  0, 0, 3, 8'h08);
    add("l3_rereq",  0, 8'h08, 0, 0, 32'h0,  0, 0,  1, 0, 3, 8'h08);
    add("l3_drop0",  0, 8'h00, 0, 0, 32'h0,  0, 0,  1, 0, 3, 8'h08);
    add("l3_drop1",  0, 8'h00, 0, 0, 32'h0,  0, 0,  1, 0, 3, 8'h08);
    add("l3_drop2",  0, 8'h00, 0, 0, 32'h0,  0, 0,  1, 0, 0, 8'h00);
    add("l3_withdr", 0, 8'h00, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);
    add("wr_edge25", 0, 8'h00, 1, 0, 32'h25, 0, 0,  0, 0, 0, 8'h00);
    add("wr_enFF",   0, 8'h00, 1, 1, 32'hFF, 0, 0,  0, 0, 0, 8'h00);
    add("p25_sync1", 0, 8'h24, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);
    add("p25_sync2", 0, 8'h00, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);
    add("p25_pend",  0, 8'h00, 0, 0, 32'h0,  0, 0,  0, 0, 5, 8'h24);
    add("p25_req5",  0, 8'h00, 0, 0, 32'h0,  0, 0,  1, 0, 5, 8'h24);
    add("p25_ack5",  0, 8'h00, 0, 0, 32'h0,  1, 0,  0, 1, 2, 8'h04);
    add("p25_eret5", 0, 8'h00, 0, 0, 32'h0,  0, 1,  0, 0, 2, 8'h04);
    add("p25_req2",  0, 8'h00, 0, 0, 32'h0,  0, 0,  1, 0, 2, 8'h04);
    add("p25_ack2",  0, 8'h00, 0, 0, 32'h0,  1, 0,  0, 1, 0, 8'h00);
    add("p25_eret2", 0, 8'h00, 0, 0, 32'h0,  0, 1,  0, 0, 0, 8'h00);
    add("w1c_s1",    0, 8'h04, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);
    add("w1c_s2",    0, 8'h00, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);
    add("w1c_pend",  0, 8'h00, 0, 0, 32'h0,  0, 0,  0, 0, 2, 8'h04);
    add("w1c_req",   0, 8'h04, 0, 0, 32'h0,  0, 0,  1, 0, 2, 8'h04);
    add("w1c_edge2", 0, 8'h00, 0, 0, 32'h0,  0, 0,  1, 0, 2, 8'h04);
    add("w1c_race",  0, 8'h00, 1, 3, 32'h04, 0, 0,  1, 0, 2, 8'h04, 1, 32'h04);
    add("w1c_clr",   0, 8'h00, 1, 3, 32'h04, 0, 0,  1, 0, 0, 8'h00, 1, 32'h00);
    add("w1c_withd", 0, 8'h00, 0, 0, 32'h0,  0, 0,  0, 0, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].irq, vecs[i].we, vecs[i].addr, vecs[i].data,
            vecs[i].ack, vecs[i].eret);
      check_out(vecs[i].name, vecs[i].req, vecs[i].svc, vecs[i].id, vecs[i].pend);
      if (vecs[i].chk_rd) check_val({vecs[i].name, "_rd"}, Cfg_rd_data, vecs[i].rd);
    end

    // Timer, period 4; continuous W1C on line 7 so only fire edges leave it set.
    drive(0, 8'h00, 1, 1, 32'h80, 0, 0);
    drive(0, 8'h00, 1, 2, 32'h4,  0, 0);
    check_val("tmr_cmp4_rd", Cfg_rd_data, 32'h4);
    for (int k = 1; k <= 12; k++) begin
      drive(0, 8'h00, 1, 3, 32'h80, 0, 0);
      check_val($sformatf("tmr4_k%0d", k), {24'h0, Intr_pending},
                (k % 4 == 0) ? 32'h80 : 32'h00);
    end
    drive(0, 8'h00, 1, 2, 32'h0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 8'h00, 1, 3, 32'h80, 0, 0);
      check_val($sformatf("tmr_off_k%0d", k), {24'h0, Intr_pending}, 32'h00);
    end
    drive(0, 8'h00, 1, 2, 32'h1, 0, 0);
    check_val("tmr_cmp1_rd", Cfg_rd_data, 32'h1);
    for (int k = 0; k < 6; k++) begin
      drive(0, 8'h00, 1, 3, 32'h80, 0, 0);
      check_val($sformatf("tmr1_k%0d", k), {24'h0, Intr_pending}, 32'h80);
    end
    // Level-mode line 7 holds a timer event until cleared.
    drive(0, 8'h00, 1, 2, 32'h0, 0, 0);
    check_val("tmr_hold0", {24'h0, Intr_pending}, 32'h80);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 8'h00, 0, 0, 32'h0, 0, 0);
      check_val($sformatf("tmr_hold%0d", k), {24'h0, Intr_pending}, 32'h80);
    end
    drive(0, 8'h00, 1, 3, 32'h80, 0, 0);
    check_val("tmr_hold_clr", {24'h0, Intr_pending}, 32'h00);
    drive(0, 8'h00, 0, 0, 32'h0, 0, 0);
    check_out("tmr_idle", 0, 0, 0, 8'h00);

    // Reset in the middle of a service with pending 0x81.
    drive(0, 8'h00, 1, 1, 32'h81, 0, 0);
    drive(0, 8'h81, 0, 0, 32'h0, 0, 0);
    drive(0, 8'h81, 0, 0, 32'h0, 0, 0);
    drive(0, 8'h81, 0, 0, 32'h0, 0, 0);
    check_out("rs_pend", 0, 0, 7, 8'h81);
    drive(0, 8'h81, 0, 0, 32'h0, 0, 0);
    check_out("rs_req", 1, 0, 7, 8'h81);
    drive(0, 8'h81, 0, 0, 32'h0, 1, 0);
    check_out("rs_svc", 0, 1, 7, 8'h81);
    drive(1, 8'h81, 0, 1, 32'h0, 0, 0);
    check_out("rs_reset", 0, 0, 0, 8'h00);
    check_val("rs_en_rd", Cfg_rd_data, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'h01, 0, 0, 32'h0, 0, 0);
      check_out($sformatf("rs_ignore%0d", k), 0, 0, 0, 8'h00);
    end
    drive(0, 8'h01, 1, 1, 32'h01, 0, 0);
    check_out("rs_en_pend", 0, 0, 0, 8'h01);
    drive(0, 8'h01, 0, 0, 32'h0, 0, 0);
    check_out("rs_en_req", 1, 0, 0, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
